// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the response-stage owner encoding and the store byte-mask
// constants that the decoder also uses when it builds store masks.
package mem_arb_pkg;

  // Which requester the response stage is returning data to
  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_IF   = 2'b01,
    OWNER_D    = 2'b10
  } owner_e;

  // Store byte-enable patterns for byte, halfword and word stores
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant logic for the fetch/data arbiter plus the data streak counter.
// Data requests win over fetches. After MAX_DATA_BURST consecutive data
// grants while a fetch waits, the fetch is granted once.
// Ports:
//   clk, rst           clock, async active-high reset
//   if_valid, d_valid  request valids from fetch and load/store
//   flush              blocks any fetch grant this cycle
//   grant_if, grant_d  one-hot (or zero) grant, combinational
module mem_arb_prio #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic d_valid,
  input  logic flush,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_BURST);

  logic [3:0] streak;
  logic       if_ok;
  logic       burst_full;

  // Grants are zero-latency. A flushed fetch is not eligible, and in that
  // case the data side keeps the memory busy even with a full streak.
  // Grants are held off while reset is asserted so all outputs stay 0.
  always_comb begin
    if_ok      = if_valid & ~flush & ~rst;
    burst_full = (streak >= MAX_STREAK);
    grant_if   = if_ok & (~d_valid | burst_full);
    grant_d    = d_valid & ~rst & ~grant_if;
  end

  // Counts data grants that overtook a waiting fetch; saturates at the
  // burst limit and restarts whenever the fetch side is idle or served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (!if_valid || grant_if) begin
      streak <= '0;
    end else if (grant_d && (streak < MAX_STREAK)) begin
      streak <= streak + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch
// and the load/store path. One access per cycle; read data returns one
// cycle after the grant and is routed to the requester that was granted.
// Ports:
//   clk, rst                 clock, async active-high reset
//   if_req_*                 fetch request (valid/addr) and grant (ready)
//   if_resp_*                fetch response pulse and word
//   d_req_*                  load/store request and grant
//   d_resp_*                 load data or store ack pulse (data 0 on ack)
//   flush                    kills fetch grant and pending fetch response
//   mem_*                    unified memory macro interface
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [3:0]        d_req_mask,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  input  logic              flush,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   grant_if;
  logic   grant_d;
  owner_e owner;
  owner_e owner_next;
  logic   owner_write;
  logic   owner_write_next;
  logic   unused_low_bits;

  // The memory is word addressed; byte offsets are simply dropped
  assign unused_low_bits = ^{if_req_addr[1:0], d_req_addr[1:0]};

  mem_arb_prio #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .flush    (flush),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // Memory drive follows the winner; the bus is quiet (all 0) when idle.
  // Write data is presented on every grant, only mem_we makes it stick.
  always_comb begin
    mem_en    = grant_if | grant_d;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr  = {d_req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = d_req_wdata;
      if (d_req_we) begin
        mem_we = d_req_mask;
      end
    end else if (grant_if) begin
      mem_addr  = {if_req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = d_req_wdata;
    end
  end

  // Response stage: remember who owns the data coming back next cycle
  always_comb begin
    owner_next       = OWNER_NONE;
    owner_write_next = 1'b0;
    if (grant_d) begin
      owner_next       = OWNER_D;
      owner_write_next = d_req_we;
    end else if (grant_if) begin
      owner_next = OWNER_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= OWNER_NONE;
      owner_write <= 1'b0;
    end else begin
      owner       <= owner_next;
      owner_write <= owner_write_next;
    end
  end

  // A flush in the response cycle drops the fetched word: it belongs to
  // the wrong path. Data buses read 0 whenever their valid is low.
  always_comb begin
    if_resp_valid = (owner == OWNER_IF) & ~flush;
    d_resp_valid  = (owner == OWNER_D);
    if_resp_data  = if_resp_valid ? mem_rdata : '0;
    d_resp_data   = (d_resp_valid && !owner_write) ? mem_rdata : '0;
  end

endmodule
